strobe_stretcher: RTL and testbench
===================================

# strobe_stretcher

Converts single-cycle strobes (as produced by the edge detector) back into level pulses of programmable length on the same clock. Each accepted strobe drives `out_signal` high for exactly `in_length` cycles, then enforces a fixed low holdoff before the next pulse. It sits on the output side of strobe-based control paths: LED/indicator drive, trigger outputs, and enable windows for downstream logic.

## Interface
- `WIDTH_BITS`, 16: width of the length field and internal counter; maximum pulse length is 2^WIDTH_BITS-1 cycles.
- `HOLDOFF`, 2: number of forced-low cycles after each pulse; 0 is legal.

- `in_clock`  input  1  single system clock; all logic on its rising edge.
- `in_reset_n`  input  1  reset, synchronous, active-low.
- `in_strobe`  input  1  one-cycle request to start or extend a pulse.
- `in_length`  input  WIDTH_BITS  pulse length in cycles; sampled only in a cycle where `in_strobe` is accepted.
- `in_retrigger`  input  1  1 = a strobe during an active pulse restarts it with the new length; 0 = such a strobe is dropped.
- `out_signal`  output  1  stretched pulse, registered.
- `out_busy`  output  1  high in HIGH and GAP states, registered.
- `out_done`  output  1  one-cycle strobe in the first low cycle after a pulse ends.
- `out_dropped`  output  1  one-cycle strobe, one cycle after an ignored strobe.

## Operation
- States: IDLE, HIGH, GAP. The state resets to IDLE.
- IDLE:
  - `in_strobe`=1 with `in_length`≠0: load the counter with `in_length` and go to HIGH.
  - `in_strobe`=1 with `in_length`=0: stay in IDLE and pulse `out_dropped`.
- HIGH:
  - `out_signal`=1. The counter decrements each cycle.
  - When the counter reaches 1 with no accepted strobe, go to GAP if `HOLDOFF`>0, else go to IDLE.
- Strobe during HIGH:
  - `in_retrigger`=1 and `in_length`≠0: reload the counter with `in_length` and stay in HIGH. The pulse continues for `in_length` more cycles, counted from the cycle after the strobe.
  - Otherwise: no change to the pulse; pulse `out_dropped`.
- GAP:
  - `out_signal`=0 and `out_busy`=1 for exactly `HOLDOFF` cycles, using a separate holdoff counter. Then go to IDLE.
  - Any strobe in GAP is dropped.
- `out_done` fires once per completed pulse, in the first cycle `out_signal` is 0. It does not fire on retrigger extensions.
- Arithmetic: unsigned down-counters. No wrap: the counter never decrements below 1 while in HIGH.

## Timing
- Reset (`in_reset_n`=0 at a clock edge): the next cycle has `out_signal`=`out_busy`=`out_done`=`out_dropped`=0 and state IDLE. Counters clear.
- Reset asserted mid-pulse or mid-GAP aborts immediately. `out_done` does not fire.
- Latency: strobe sampled at edge k gives `out_signal`=1 for cycles k+1 … k+L.
- `out_busy` rises with `out_signal`. It falls after the last GAP cycle, or with `out_signal` when `HOLDOFF`=0.
- Retrigger on the final HIGH cycle (counter=1) is accepted. `out_signal` stays high with no low gap.
- `HOLDOFF`=0: a strobe in the first low cycle (the same cycle `out_done`=1) is accepted, so the minimum low time between pulses is 1 cycle.
- `HOLDOFF`=H>0: the first acceptable strobe arrives H cycles after the falling edge of `out_signal`.
- `out_dropped` and `out_done` are registered. Both can be high in the same cycle.

## Structure
- Shared package `strobe_pkg`: state encoding constants (IDLE=0, HIGH=1, GAP=2) and the default `WIDTH_BITS`. The package is reusable by the edge detector bench and future strobe blocks.
- One sub-module: `load_down_counter`. It provides a parameterised load/decrement counter with an `is_one` flag. It is instantiated twice: pulse length at `WIDTH_BITS`, holdoff at $clog2(`HOLDOFF`+1).
- Top level contains the FSM and the output registers only.

## Test plan
- Reset then single strobe with `in_length`=5 at cycle 10 -> `out_signal` high in cycles 11–15, `out_done`=1 in cycle 16, `out_busy` low from cycle 18 (`HOLDOFF`=2).
- Strobe with `in_length`=0 in IDLE -> `out_signal` stays 0, `out_dropped`=1 the next cycle.
- `in_retrigger`=1, `in_length`=4 at cycle 0, then `in_length`=3 at cycle 3 -> `out_signal` high in cycles 1–6, a single `out_done` in cycle 7.
- `in_retrigger`=0, strobe during HIGH and strobe during GAP -> pulse unchanged, two `out_dropped` pulses, no new pulse.
- `HOLDOFF`=0: pulse `in_length`=2, strobe in the `out_done` cycle -> second pulse starts next cycle, low time exactly 1 cycle.
- `in_reset_n` driven low mid-pulse (`in_length`=100) -> all outputs 0 the next cycle, no `out_done`, a fresh strobe behaves as after power-up.

Source files
------------

// File: rtl/strobe_pkg.sv
// strobe_pkg: shared definitions for strobe-based control blocks.
//   strobe_state_t            - FSM state encoding (IDLE=0, HIGH=1, GAP=2)
//   STROBE_WIDTH_BITS_DEFAULT - default width of length fields / counters
package strobe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } strobe_state_t;

  localparam int STROBE_WIDTH_BITS_DEFAULT = 16;

endpackage

// File: rtl/strobe_stretcher_load_down_counter.sv
// load_down_counter: loadable unsigned down-counter with an is_one flag.
//   in_clock    - rising-edge clock
//   in_reset_n  - synchronous active-low reset, clears the count
//   load        - load load_value (has priority over dec)
//   load_value  - value to load
//   dec         - decrement request; ignored at 1 or 0 so the count never wraps
//   is_one      - count == 1
module load_down_counter #(
  parameter int W = 16
) (
  input  logic         in_clock,
  input  logic         in_reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         is_one
);

  logic [W-1:0] count;

  assign is_one = (count == W'(1));

  always_ff @(posedge in_clock) begin
    if (!in_reset_n)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (dec && !is_one && (count != '0))
      count <= count - W'(1);
  end

endmodule

// File: rtl/strobe_stretcher.sv
// strobe_stretcher: turns one-cycle strobes into level pulses of in_length
// cycles, followed by HOLDOFF forced-low cycles.
//   in_clock     - system clock, rising edge
//   in_reset_n   - synchronous active-low reset
//   in_strobe    - start / retrigger request
//   in_length    - pulse length, sampled when a strobe is accepted
//   in_retrigger - 1: strobe during HIGH reloads the length
//   out_signal   - stretched pulse (registered)
//   out_busy     - high in HIGH and GAP (registered)
//   out_done     - one-cycle strobe in the first low cycle after a pulse
//   out_dropped  - one-cycle strobe the cycle after an ignored strobe
module strobe_stretcher
  import strobe_pkg::*;
#(
  parameter int WIDTH_BITS = STROBE_WIDTH_BITS_DEFAULT,
  parameter int HOLDOFF    = 2
) (
  input  logic                  in_clock,
  input  logic                  in_reset_n,
  input  logic                  in_strobe,
  input  logic [WIDTH_BITS-1:0] in_length,
  input  logic                  in_retrigger,
  output logic                  out_signal,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_dropped
);

  // Holdoff counter needs at least one bit even when HOLDOFF is 0.
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  strobe_state_t state, state_nxt;
  logic len_load, len_dec, len_is_one;
  logic hold_load, hold_dec, hold_is_one;
  logic drop;
  logic len_nz;

  assign len_nz = |in_length;

  load_down_counter #(.W(WIDTH_BITS)) u_len_cnt (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .load       (len_load),
    .load_value (in_length),
    .dec        (len_dec),
    .is_one     (len_is_one)
  );

  load_down_counter #(.W(HW)) u_hold_cnt (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .load       (hold_load),
    .load_value (HW'(HOLDOFF)),
    .dec        (hold_dec),
    .is_one     (hold_is_one)
  );

  always_comb begin
    state_nxt = state;
    len_load  = 1'b0;
    len_dec   = 1'b0;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (in_strobe) begin
          if (len_nz) begin
            len_load  = 1'b1;
            state_nxt = HIGH;
          end else begin
            drop = 1'b1;
          end
        end
      end
      HIGH: begin
        if (in_strobe && in_retrigger && len_nz) begin
          // Reload wins over end-of-pulse, so a retrigger on the last
          // cycle extends the pulse with no low gap.
          len_load = 1'b1;
        end else begin
          drop = in_strobe;
          if (len_is_one) begin
            if (HOLDOFF > 0) begin
              hold_load = 1'b1;
              state_nxt = GAP;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            len_dec = 1'b1;
          end
        end
      end
      GAP: begin
        drop = in_strobe;
        if (hold_is_one)
          state_nxt = IDLE;
        else
          hold_dec = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      out_signal  <= 1'b0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
      out_dropped <= 1'b0;
    end else begin
      out_signal  <= (state_nxt == HIGH);
      out_busy    <= (state_nxt != IDLE);
      out_done    <= (state == HIGH) && (state_nxt != HIGH);
      out_dropped <= drop;
    end
  end

endmodule

// File: tb/tb_strobe_stretcher.sv
module tb_strobe_stretcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_strobe = 1'b0;
  logic [15:0] in_length = '0;
  logic        in_retrigger = 1'b0;
  logic        out_signal, out_busy, out_done, out_dropped;

  logic        strobe0 = 1'b0;
  logic [15:0] length0 = '0;
  logic        sig0, busy0, done0, drop0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  strobe_stretcher #(.WIDTH_BITS(16), .HOLDOFF(2)) dut (
    .in_clock     (clk),
    .in_reset_n   (rst_n),
    .in_strobe    (in_strobe),
    .in_length    (in_length),
    .in_retrigger (in_retrigger),
    .out_signal   (out_signal),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_dropped  (out_dropped)
  );

  strobe_stretcher #(.WIDTH_BITS(16), .HOLDOFF(0)) dut0 (
    .in_clock     (clk),
    .in_reset_n   (rst_n),
    .in_strobe    (strobe0),
    .in_length    (length0),
    .in_retrigger (1'b0),
    .out_signal   (sig0),
    .out_busy     (busy0),
    .out_done     (done0),
    .out_dropped  (drop0)
  );

  // Advance one cycle; inputs set after this apply to the new cycle and
  // outputs read after this belong to it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] act;
    rst_n = 1'b0;
    step();
    step();
    act = {out_signal, out_busy, out_done, out_dropped};
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL reset sig/busy/done/drop got %b want 0000", act);
    end
    act = {sig0, busy0, done0, drop0};
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL reset_h0 sig/busy/done/drop got %b want 0000", act);
    end
    rst_n = 1'b1;
    step();
  endtask

  // len=5 strobe: high 1..5, done 6, gap 6..7, idle from 8
  task automatic test_single();
    logic [3:0] act, exp;
    in_retrigger = 1'b0;
    in_strobe = 1'b1;
    in_length = 16'd5;
    step();
    in_strobe = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp = {i <= 5, i <= 7, i == 6, 1'b0};
      act = {out_signal, out_busy, out_done, out_dropped};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL single c%0d sig/busy/done/drop got %b want %b", i, act, exp);
      end
      step();
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] act;
    in_strobe = 1'b1;
    in_length = 16'd0;
    step();
    in_strobe = 1'b0;
    act = {out_signal, out_busy, out_done, out_dropped};
    checks++;
    if (act !== 4'b0001) begin
      errors++;
      $display("FAIL zero_len c1 sig/busy/done/drop got %b want 0001", act);
    end
    step();
    act = {out_signal, out_busy, out_done, out_dropped};
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL zero_len c2 sig/busy/done/drop got %b want 0000", act);
    end
  endtask

  // len=4 at c0, len=3 at c3: high 1..6, done 7, gap 7..8
  task automatic test_retrigger();
    logic [3:0] act, exp;
    int ndone = 0;
    in_retrigger = 1'b1;
    in_strobe = 1'b1;
    in_length = 16'd4;
    step();
    for (int i = 1; i <= 9; i++) begin
      in_strobe = (i == 3);
      in_length = 16'd3;
      exp = {i <= 6, i <= 8, i == 7, 1'b0};
      act = {out_signal, out_busy, out_done, out_dropped};
      if (out_done === 1'b1) ndone++;
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL retrigger c%0d sig/busy/done/drop got %b want %b", i, act, exp);
      end
      step();
    end
    in_strobe = 1'b0;
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL retrigger done_count got %0d want 1", ndone);
    end
  endtask

  // Retrigger on the last HIGH cycle: len=2 at c0, len=2 at c2 -> high 1..4
  task automatic test_back_to_back();
    logic [3:0] act, exp;
    in_retrigger = 1'b1;
    in_strobe = 1'b1;
    in_length = 16'd2;
    step();
    for (int i = 1; i <= 7; i++) begin
      in_strobe = (i == 2);
      exp = {i <= 4, i <= 6, i == 5, 1'b0};
      act = {out_signal, out_busy, out_done, out_dropped};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL back_to_back c%0d sig/busy/done/drop got %b want %b", i, act, exp);
      end
      step();
    end
    in_strobe = 1'b0;
  endtask

  // len=4 at c0; strobes at c2 (HIGH) and c5 (GAP) are both dropped
  task automatic test_no_retrigger();
    logic [3:0] act, exp;
    in_retrigger = 1'b0;
    in_strobe = 1'b1;
    in_length = 16'd4;
    step();
    for (int i = 1; i <= 9; i++) begin
      in_strobe = (i == 2) || (i == 5);
      in_length = 16'd9;
      exp = {i <= 4, i <= 6, i == 5, (i == 3) || (i == 6)};
      act = {out_signal, out_busy, out_done, out_dropped};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL no_retrigger c%0d sig/busy/done/drop got %b want %b", i, act, exp);
      end
      step();
    end
    in_strobe = 1'b0;
  endtask

  // HOLDOFF=0: len=2 at c0, strobe at c3 (done cycle) -> high 1..2, 4..5
  task automatic test_holdoff0();
    logic [3:0] act, exp;
    strobe0 = 1'b1;
    length0 = 16'd2;
    step();
    for (int i = 1; i <= 7; i++) begin
      strobe0 = (i == 3);
      exp = {(i == 1) || (i == 2) || (i == 4) || (i == 5),
             (i == 1) || (i == 2) || (i == 4) || (i == 5),
             (i == 3) || (i == 6), 1'b0};
      act = {sig0, busy0, done0, drop0};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL holdoff0 c%0d sig/busy/done/drop got %b want %b", i, act, exp);
      end
      step();
    end
    strobe0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] act, exp;
    in_retrigger = 1'b0;
    in_strobe = 1'b1;
    in_length = 16'd100;
    step();
    in_strobe = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    checks++;
    if (out_signal !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid pre sig got %b want 1", out_signal);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      act = {out_signal, out_busy, out_done, out_dropped};
      checks++;
      if (act !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid post%0d sig/busy/done/drop got %b want 0000", i, act);
      end
      step();
    end
    in_strobe = 1'b1;
    in_length = 16'd3;
    step();
    in_strobe = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp = {i <= 3, i <= 5, i == 4, 1'b0};
      act = {out_signal, out_busy, out_done, out_dropped};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL reset_mid fresh c%0d sig/busy/done/drop got %b want %b", i, act, exp);
      end
      step();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_zero_len();
    test_retrigger();
    test_back_to_back();
    test_no_retrigger();
    test_holdoff0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
